// File: rtl/alu_writeback_if.sv
// ALU-to-writeback bundle: the ALU drives one result/branch entry per cycle,
// the writeback stage answers with alu_ok_o.
interface alu_writeback_if #(
  parameter int XLEN = 32
);
  // Handshake: an entry transfers on a rising edge where alu_ok_o is high and
  // at least one of alu_result_valid_i / alu_target_valid_i is high. alu_ok_o
  // depends only on writeback state, so the ALU may use it to decide what to present.
  logic            alu_result_valid_i;
  logic [XLEN-1:0] alu_result_i;
  logic [4:0]      alu_rd_i;
  logic            alu_target_valid_i;
  logic [XLEN-1:0] alu_target_i;
  logic            alu_ok_o;

  modport master (
    output alu_result_valid_i,
    output alu_result_i,
    output alu_rd_i,
    output alu_target_valid_i,
    output alu_target_i,
    input  alu_ok_o
  );

  modport slave (
    input  alu_result_valid_i,
    input  alu_result_i,
    input  alu_rd_i,
    input  alu_target_valid_i,
    input  alu_target_i,
    output alu_ok_o
  );
endinterface

// File: rtl/alu_writeback.sv
// Write-back stage: buffers ALU results in an in-order FIFO, shares the single
// register-file write port with load data (loads win), and emits branch redirects.
module alu_writeback #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  alu_writeback_if.slave               alu,
  input  logic                         mem_valid_i,
  input  logic [XLEN-1:0]              mem_data_i,
  input  logic [4:0]                   mem_rd_i,
  output logic                         rf_we_o,
  output logic [4:0]                   rf_waddr_o,
  output logic [XLEN-1:0]              rf_wdata_o,
  output logic                         redirect_valid_o,
  output logic [XLEN-1:0]              redirect_pc_o,
  output logic                         flush_o,
  output logic [31:0]                  retired_o,
  output logic [$clog2(DEPTH+1)-1:0]   dbg_count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  // Redirects are issued at push time, so only the write-back fields are buffered.
  logic [XLEN-1:0]  fifo_result [DEPTH];
  logic [4:0]       fifo_rd     [DEPTH];
  logic             fifo_rv     [DEPTH];

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [31:0]      retired_q;
  logic             alu_ok;
  logic             push;
  logic             pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign alu_ok       = !rst && (count < CNT_W'(DEPTH)) && !flush_o;
  assign alu.alu_ok_o = alu_ok;
  assign push         = alu_ok && (alu.alu_result_valid_i || alu.alu_target_valid_i);
  // Loads own the write port whenever present; the FIFO only drains in idle memory cycles.
  assign pop          = !rst && !mem_valid_i && (count != '0);
  assign flush_o      = redirect_valid_o;
  assign retired_o    = retired_q;
  assign dbg_count_o  = count;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_result[wr_ptr] <= alu.alu_result_i;
      fifo_rd[wr_ptr]     <= alu.alu_rd_i;
      fifo_rv[wr_ptr]     <= alu.alu_result_valid_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr           <= '0;
      wr_ptr           <= '0;
      count            <= '0;
      rf_we_o          <= 1'b0;
      rf_waddr_o       <= '0;
      rf_wdata_o       <= '0;
      redirect_valid_o <= 1'b0;
      redirect_pc_o    <= '0;
      retired_q        <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);

      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase

      redirect_valid_o <= push && alu.alu_target_valid_i;
      if (push && alu.alu_target_valid_i) redirect_pc_o <= alu.alu_target_i;

      if (mem_valid_i) begin
        rf_we_o    <= (mem_rd_i != 5'd0);
        rf_waddr_o <= mem_rd_i;
        rf_wdata_o <= mem_data_i;
        retired_q  <= retired_q + 32'd1;
      end else if (pop) begin
        rf_we_o    <= fifo_rv[rd_ptr] && (fifo_rd[rd_ptr] != 5'd0);
        rf_waddr_o <= fifo_rd[rd_ptr];
        rf_wdata_o <= fifo_result[rd_ptr];
        retired_q  <= retired_q + 32'd1;
      end else begin
        rf_we_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_writeback.sv
// Randomised bench for alu_writeback: a queue-based reference model predicts every
// register-file write and redirect; a monitor compares them as the DUT produces them.
module tb_alu_writeback;
  localparam int XLEN  = 32;
  localparam int DEPTH = 2;
  localparam int W     = 1 + 5 + XLEN;

  logic            clk;
  logic            rst;
  logic            mem_valid;
  logic [XLEN-1:0] mem_data;
  logic [4:0]      mem_rd;
  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            flush;
  logic [31:0]     retired;
  logic [1:0]      dbg_count;

  alu_writeback_if #(.XLEN(XLEN)) alu_bus ();

  alu_writeback #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst              (rst),
    .alu              (alu_bus.slave),
    .mem_valid_i      (mem_valid),
    .mem_data_i       (mem_data),
    .mem_rd_i         (mem_rd),
    .rf_we_o          (rf_we),
    .rf_waddr_o       (rf_waddr),
    .rf_wdata_o       (rf_wdata),
    .redirect_valid_o (redirect_valid),
    .redirect_pc_o    (redirect_pc),
    .flush_o          (flush),
    .retired_o        (retired),
    .dbg_count_o      (dbg_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // scoreboard state: expected writes {we, addr, data} and expected redirect targets
  logic [W-1:0]    exp_q[$];
  logic [XLEN-1:0] exp_redir_q[$];
  // reference model: ALU entries waiting for the write port, as {we, rd, result}
  logic [W-1:0]    m_fifo[$];
  bit              m_flush = 1'b0;
  logic [31:0]     mon_last = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // driver: called at a falling edge; presents one cycle of stimulus and advances the model
  task automatic cycle(input bit rv, input logic [31:0] res, input logic [4:0] rd,
                       input bit tv, input logic [31:0] tgt,
                       input bit mv, input logic [31:0] md, input logic [4:0] mrd,
                       output bit acc);
    bit exp_ok;
    alu_bus.alu_result_valid_i = rv;
    alu_bus.alu_result_i       = res;
    alu_bus.alu_rd_i           = rd;
    alu_bus.alu_target_valid_i = tv;
    alu_bus.alu_target_i       = tgt;
    mem_valid = mv;
    mem_data  = md;
    mem_rd    = mrd;
    #1;
    exp_ok = (m_fifo.size() < DEPTH) && !m_flush;
    check("alu_ok", {63'd0, alu_bus.alu_ok_o}, {63'd0, exp_ok});
    acc = exp_ok && (rv || tv);
    if (mv) exp_q.push_back({mrd != 5'd0, mrd, md});
    else if (m_fifo.size() > 0) exp_q.push_back(m_fifo.pop_front());
    if (acc) m_fifo.push_back({rv && (rd != 5'd0), rd, res});
    m_flush = acc && tv;
    if (acc && tv) exp_redir_q.push_back(tgt);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, acc);
  endtask

  // one reset cycle with a live ALU entry presented, which must be ignored
  task automatic do_reset();
    rst = 1'b1;
    alu_bus.alu_result_valid_i = 1'b1;
    alu_bus.alu_result_i       = 32'hDEAD_BEEF;
    alu_bus.alu_rd_i           = 5'd3;
    alu_bus.alu_target_valid_i = 1'b1;
    alu_bus.alu_target_i       = 32'h0000_0BAD;
    mem_valid = 1'b0;
    m_fifo.delete();
    m_flush = 1'b0;
    #1;
    check("ok_in_reset", {63'd0, alu_bus.alu_ok_o}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // monitor: samples just after each rising edge
  initial begin
    bit retired_now;
    logic [W-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        check("rst_rf_we", {63'd0, rf_we}, 64'd0);
        check("rst_waddr", {59'd0, rf_waddr}, 64'd0);
        check("rst_wdata", {32'd0, rf_wdata}, 64'd0);
        check("rst_redirect", {63'd0, redirect_valid}, 64'd0);
        check("rst_pc", {32'd0, redirect_pc}, 64'd0);
        check("rst_flush", {63'd0, flush}, 64'd0);
        check("rst_retired", {32'd0, retired}, 64'd0);
        check("rst_count", {62'd0, dbg_count}, 64'd0);
        exp_q.delete();
        exp_redir_q.delete();
        mon_last = '0;
      end else begin
        retired_now = (retired != mon_last);
        check("retire_event", {63'd0, retired_now}, {63'd0, exp_q.size() > 0});
        if (retired_now && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("rf_write", {26'd0, rf_we, rf_waddr, rf_wdata}, {26'd0, e});
          check("retired_step", {32'd0, retired}, {32'd0, mon_last + 32'd1});
        end else begin
          check("rf_we_idle", {63'd0, rf_we}, 64'd0);
        end
        mon_last = retired;
        check("redirect_event", {63'd0, redirect_valid}, {63'd0, exp_redir_q.size() > 0});
        check("flush_eq_redirect", {63'd0, flush}, {63'd0, redirect_valid});
        if (redirect_valid && exp_redir_q.size() > 0)
          check("redirect_pc", {32'd0, redirect_pc}, {32'd0, exp_redir_q.pop_front()});
      end
    end
  end

  // watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit acc;
    int idx;
    rst = 1'b1;
    alu_bus.alu_result_valid_i = 1'b0;
    alu_bus.alu_result_i       = '0;
    alu_bus.alu_rd_i           = '0;
    alu_bus.alu_target_valid_i = 1'b0;
    alu_bus.alu_target_i       = '0;
    mem_valid = 1'b0;
    mem_data  = '0;
    mem_rd    = '0;
    @(negedge clk);
    do_reset();
    idle(2);

    // single add
    cycle(1, 32'h0000_002A, 5'd5, 0, 0, 0, 0, 0, acc);
    idle(3);
    check("add_retired", {32'd0, retired}, 64'd1);

    // memory priority with ALU backpressure
    idx = 0;
    for (int c = 0; c < 20 && idx < 3; c++) begin
      cycle(1, 32'h100 + idx, 5'(idx + 1), 0, 0, c < 4, 32'hA0 + c, 5'(10 + c), acc);
      if (acc) idx++;
    end
    idle(5);
    check("prio_retired", {32'd0, retired}, 64'd8);

    // branch only, then an ALU entry in the flush cycle that must be dropped
    cycle(0, 0, 0, 1, 32'h0000_1000, 0, 0, 0, acc);
    cycle(1, 32'h0000_0077, 5'd9, 0, 0, 0, 0, 0, acc);
    check("flush_drop", {63'd0, acc}, 64'd0);
    idle(3);

    // JAL-style
    cycle(1, 32'h0000_0104, 5'd1, 1, 32'h0000_2000, 0, 0, 0, acc);
    idle(3);

    // x0 write and retired counter wrap
    dut.retired_q = 32'hFFFF_FFFF;
    mon_last      = 32'hFFFF_FFFF;
    cycle(1, 32'hFFFF_FFFF, 5'd0, 0, 0, 0, 0, 0, acc);
    idle(2);
    check("wrap_retired", {32'd0, retired}, 64'd0);

    // mid-operation reset with the FIFO full and a redirect pending
    cycle(1, 32'h0000_0700, 5'd7, 0, 0, 1, 32'h55, 5'd4, acc);
    cycle(1, 32'h0000_0800, 5'd8, 1, 32'h0000_3000, 1, 32'h66, 5'd6, acc);
    check("full_count", {62'd0, dbg_count}, 64'd2);
    check("redirect_pending", {63'd0, redirect_valid}, 64'd1);
    do_reset();
    idle(4);

    // randomised traffic
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 1), $urandom, 5'($urandom_range(0, 31)),
            ($urandom_range(0, 7) == 0), $urandom,
            ($urandom_range(0, 2) == 0), $urandom, 5'($urandom_range(0, 31)), acc);
    end
    idle(8);
    check("drain_writes", {32'd0, 32'(exp_q.size())}, 64'd0);
    check("drain_redirects", {32'd0, 32'(exp_redir_q.size())}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
